// File: rtl/twos_comp_serial_pkg.sv
// Package: twos_pkg
// Purpose: shared types, state codes and helpers for the serial two's-complement
//          engine and its slice.
//   tc_mode_e : operation select carried on in_mode (PASS / NEG / ABS / ONES)
//   IDLE/RUN/DONE : engine state codes
//   chunks()  : number of BPC-wide chunks that make up a WIDTH-bit word
package twos_pkg;

  typedef enum logic [1:0] {
    TC_PASS = 2'b00,
    TC_NEG  = 2'b01,
    TC_ABS  = 2'b10,
    TC_ONES = 2'b11
  } tc_mode_e;

  // Engine states, kept as plain 2-bit codes so they line up with older
  // blocks that compare raw state values.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic int chunks(input int width, input int bpc);
    return width / bpc;
  endfunction

endpackage

// File: rtl/twos_comp_serial_if.sv
// Interface: twos_comp_serial_if
// Purpose: operand and result handshakes of the serial two's-complement engine.
//   in_valid/in_ready/in_data/in_mode     : operand channel (producer -> engine)
//   out_valid/out_ready/out_data/out_ovf/out_zero : result channel (engine -> consumer)
//   master modport : the side that supplies operands and consumes results
//   slave modport  : the engine itself
interface twos_comp_serial_if #(
  parameter int WIDTH = 12
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;
  logic             out_zero;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_ovf, out_zero
  );

endinterface

// File: rtl/twos_comp_serial_slice.sv
// Module: tc_slice
// Purpose: combinational BPC-bit slice of the two's-complement engine using the
//          copy-until-first-1-then-invert rule (no carry chain).
//   x        in  : operand chunk, bit 0 is the least significant
//   seen_in  in  : a 1 has already been seen in lower chunks
//   inv      in  : apply the negate rule (NEG, or ABS of a negative operand)
//   ones     in  : plain bitwise invert (ONES mode)
//   o        out : result chunk
//   seen_out out : seen flag handed to the next chunk
module tc_slice #(
  parameter int BPC = 1
) (
  input  logic [BPC-1:0] x,
  input  logic           seen_in,
  input  logic           inv,
  input  logic           ones,
  output logic [BPC-1:0] o,
  output logic           seen_out
);

  logic seenRun;

  // Walk the chunk LSB to MSB: bits are copied until the first 1 has gone
  // past, every later bit is inverted. The 1 itself is copied, which is why
  // the seen flag is updated only after the bit is produced.
  always_comb begin
    seenRun = seen_in;
    o       = '0;
    for (int i = 0; i < BPC; i++) begin
      if (ones) begin
        o[i] = ~x[i];
      end else if (inv && seenRun) begin
        o[i] = ~x[i];
      end else begin
        o[i] = x[i];
      end
      seenRun = seenRun | x[i];
    end
    seen_out = seenRun;
  end

endmodule

// File: rtl/twos_comp_serial.sv
// Module: twos_comp_serial
// Purpose: handshaked serial two's-complement engine. Takes a WIDTH-bit operand
//          and a mode, produces PASS / NEG / ABS / ONES results LSB-first, BPC
//          bits per cycle, and holds the result until it is accepted.
//   t_clk  in  : clock, rising edge
//   t_rst  in  : synchronous active-high reset, aborts any word in flight
//   bus    slave modport of twos_comp_serial_if (operand and result channels)
//   busy   out : engine is not idle
module twos_comp_serial
  import twos_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int BPC   = 1
) (
  input  logic                t_clk,
  input  logic                t_rst,
  twos_comp_serial_if.slave   bus,
  output logic                busy
);

  localparam int NCHUNK = chunks(WIDTH, BPC);
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Reject geometries the slice/shift datapath cannot handle.
  generate
    if ((WIDTH < 2) || (BPC < 1) || ((WIDTH % BPC) != 0)) begin : g_bad_params
      $error("twos_comp_serial: WIDTH must be >= 2 and a multiple of BPC");
    end
  endgenerate

  logic [1:0]       state_q,   state_d;
  logic [CW-1:0]    count_q,   count_d;
  logic             seen_q,    seen_d;
  logic             inv_q,     inv_d;
  logic             ones_q,    ones_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic [WIDTH-1:0] result_q,  result_d;
  logic             ovf_q,     ovf_d;
  logic             zero_q,    zero_d;

  tc_mode_e             modeIn;
  logic                 inReady;
  logic                 accept;
  logic                 lastChunk;
  logic [BPC-1:0]       sliceOut;
  logic                 sliceSeen;
  logic [WIDTH+BPC-1:0] shiftCat;
  logic [WIDTH-1:0]     resultShift;

  assign modeIn    = tc_mode_e'(bus.in_mode);
  assign inReady   = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign accept    = bus.in_valid && inReady;
  assign lastChunk = (count_q == CW'(NCHUNK - 1));

  tc_slice #(
    .BPC(BPC)
  ) u_slice (
    .x        (operand_q[BPC-1:0]),
    .seen_in  (seen_q),
    .inv      (inv_q),
    .ones     (ones_q),
    .o        (sliceOut),
    .seen_out (sliceSeen)
  );

  // New result bits enter at the top and everything moves down one chunk,
  // so after the last chunk the first-produced bits have reached bit 0.
  assign shiftCat    = {sliceOut, result_q};
  assign resultShift = shiftCat[WIDTH+BPC-1:BPC];

  // Next-state logic. The mode is kept only in decoded form (inv/ones);
  // the operand sign is consumed here at load, the only point where the
  // MSB is needed. Flags are computed from the finished result: with inv
  // set, only the most-negative operand maps onto 100..0.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    seen_d    = seen_q;
    inv_d     = inv_q;
    ones_d    = ones_q;
    operand_d = operand_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    zero_d    = zero_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
        end
      end
      RUN: begin
        operand_d = operand_q >> BPC;
        result_d  = resultShift;
        seen_d    = sliceSeen;
        count_d   = count_q + 1'b1;
        if (lastChunk) begin
          state_d = DONE;
          count_d = '0;
          ovf_d   = inv_q && (resultShift == MOST_NEG);
          zero_d  = (resultShift == '0);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = accept ? RUN : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      operand_d = bus.in_data;
      inv_d     = (modeIn == TC_NEG) || ((modeIn == TC_ABS) && bus.in_data[WIDTH-1]);
      ones_d    = (modeIn == TC_ONES);
      seen_d    = 1'b0;
      count_d   = '0;
      result_d  = '0;
      ovf_d     = 1'b0;
      zero_d    = 1'b0;
    end
  end

  // State registers; reset drops any word in flight without emitting it.
  always_ff @(posedge t_clk) begin
    if (t_rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      seen_q    <= 1'b0;
      inv_q     <= 1'b0;
      ones_q    <= 1'b0;
      operand_q <= '0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      seen_q    <= seen_d;
      inv_q     <= inv_d;
      ones_q    <= ones_d;
      operand_q <= operand_d;
      result_q  <= result_d;
      ovf_q     <= ovf_d;
      zero_q    <= zero_d;
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = result_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.out_zero  = zero_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_twos_comp_serial.sv
// Testbench: tb_twos_comp_serial
// Purpose: drives a BPC=1 engine (directed, hold, back-to-back, abort, random)
//          and a BPC=4 engine (latency, random sweep), both WIDTH=12, and
//          compares results against an arithmetic reference model.
module tb_twos_comp_serial;
  import twos_pkg::*;

  localparam int W = 12;

  typedef struct {
    logic [1:0]  m;
    logic [11:0] d;
    logic [11:0] e;
    logic        ovf;
    logic        zero;
  } vec_t;

  logic t_clk = 1'b0;
  logic t_rst;
  logic busyA;
  logic busyB;
  int   checkCount = 0;
  int   passCount  = 0;
  vec_t dirVecs[10];

  twos_comp_serial_if #(.WIDTH(W)) busA ();
  twos_comp_serial_if #(.WIDTH(W)) busB ();

  twos_comp_serial #(.WIDTH(W), .BPC(1)) dutA (
    .t_clk (t_clk),
    .t_rst (t_rst),
    .bus   (busA),
    .busy  (busyA)
  );

  twos_comp_serial #(.WIDTH(W), .BPC(4)) dutB (
    .t_clk (t_clk),
    .t_rst (t_rst),
    .bus   (busB),
    .busy  (busyB)
  );

  // Free-running clock, 10 time units per period.
  always #5 t_clk = ~t_clk;

  // Every comparison of the bench passes through here.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: plain modular arithmetic on the operand value, {zero, ovf, data}.
  function automatic logic [13:0] refModel(input logic [1:0] mode, input logic [11:0] x);
    int v;
    int r;
    logic ovf;
    v = int'(x);
    case (mode)
      2'd0:    r = v;
      2'd1:    r = (4096 - v) % 4096;
      2'd2:    r = (v >= 2048) ? (4096 - v) % 4096 : v;
      default: r = 4095 - v;
    endcase
    ovf = ((mode == 2'd1) || ((mode == 2'd2) && (v >= 2048))) && (v == 2048);
    return {(r == 0), ovf, 12'(r)};
  endfunction

  // Channel accessors so one set of tasks can drive either engine.
  task automatic driveIn(input bit sel, input logic v, input logic [1:0] m, input logic [11:0] d);
    if (sel) begin
      busB.in_valid = v;
      busB.in_mode  = m;
      busB.in_data  = d;
    end else begin
      busA.in_valid = v;
      busA.in_mode  = m;
      busA.in_data  = d;
    end
  endtask

  task automatic setOutReady(input bit sel, input logic r);
    if (sel) busB.out_ready = r;
    else     busA.out_ready = r;
  endtask

  function automatic logic outValid(input bit sel);
    return sel ? busB.out_valid : busA.out_valid;
  endfunction

  function automatic logic inReady(input bit sel);
    return sel ? busB.in_ready : busA.in_ready;
  endfunction

  function automatic logic [11:0] outData(input bit sel);
    return sel ? busB.out_data : busA.out_data;
  endfunction

  function automatic logic outOvf(input bit sel);
    return sel ? busB.out_ovf : busA.out_ovf;
  endfunction

  function automatic logic outZero(input bit sel);
    return sel ? busB.out_zero : busA.out_zero;
  endfunction

  function automatic logic busyOf(input bit sel);
    return sel ? busyB : busyA;
  endfunction

  task automatic tick();
    @(posedge t_clk);
    #1;
  endtask

  // Counts edges after the accept edge until out_valid rises (bounded).
  task automatic waitResult(input bit sel, output int edges);
    edges = 0;
    while (!outValid(sel) && edges < 100) begin
      tick();
      edges++;
    end
    checkOutput("resultArrives", {31'd0, outValid(sel)}, 32'd1);
  endtask

  // One full transaction: accept, wait, compare, acknowledge.
  task automatic applyStimulus(input bit sel, input logic [1:0] m, input logic [11:0] d,
                               input logic [11:0] expData, input logic expOvf,
                               input logic expZero, input int expLat);
    int n;
    int edges;
    n = 0;
    while (!inReady(sel) && n < 200) begin
      tick();
      n++;
    end
    checkOutput("inReadyWait", {31'd0, inReady(sel)}, 32'd1);
    driveIn(sel, 1'b1, m, d);
    tick();
    driveIn(sel, 1'b0, m, d);
    waitResult(sel, edges);
    if (expLat > 0) checkOutput("latency", edges, expLat);
    checkOutput("outData", {20'd0, outData(sel)}, {20'd0, expData});
    checkOutput("outOvf",  {31'd0, outOvf(sel)},  {31'd0, expOvf});
    checkOutput("outZero", {31'd0, outZero(sel)}, {31'd0, expZero});
    setOutReady(sel, 1'b1);
    tick();
    setOutReady(sel, 1'b0);
    checkOutput("outValidDrop", {31'd0, outValid(sel)}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int edges;
    logic sawValid;
    logic [1:0]  rm;
    logic [11:0] rd;
    logic [13:0] expv;

    dirVecs[0] = '{2'd1, 12'h005, 12'hFFB, 1'b0, 1'b0};
    dirVecs[1] = '{2'd1, 12'h800, 12'h800, 1'b1, 1'b0};
    dirVecs[2] = '{2'd1, 12'h000, 12'h000, 1'b0, 1'b1};
    dirVecs[3] = '{2'd1, 12'h001, 12'hFFF, 1'b0, 1'b0};
    dirVecs[4] = '{2'd2, 12'hFF6, 12'h00A, 1'b0, 1'b0};
    dirVecs[5] = '{2'd2, 12'h07F, 12'h07F, 1'b0, 1'b0};
    dirVecs[6] = '{2'd3, 12'h0F0, 12'hF0F, 1'b0, 1'b0};
    dirVecs[7] = '{2'd0, 12'hABC, 12'hABC, 1'b0, 1'b0};
    dirVecs[8] = '{2'd3, 12'hFFF, 12'h000, 1'b0, 1'b1};
    dirVecs[9] = '{2'd2, 12'h800, 12'h800, 1'b1, 1'b0};

    t_rst = 1'b1;
    driveIn(1'b0, 1'b0, 2'd0, 12'h000);
    driveIn(1'b1, 1'b0, 2'd0, 12'h000);
    setOutReady(1'b0, 1'b0);
    setOutReady(1'b1, 1'b0);
    repeat (3) tick();
    t_rst = 1'b0;

    $display("[TB] reset state");
    for (int s = 0; s < 2; s++) begin
      checkOutput("rstInReady",  {31'd0, inReady(s[0])},  32'd1);
      checkOutput("rstOutValid", {31'd0, outValid(s[0])}, 32'd0);
      checkOutput("rstBusy",     {31'd0, busyOf(s[0])},   32'd0);
      checkOutput("rstOutData",  {20'd0, outData(s[0])},  32'd0);
      checkOutput("rstOvf",      {31'd0, outOvf(s[0])},   32'd0);
      checkOutput("rstZero",     {31'd0, outZero(s[0])},  32'd0);
    end

    $display("[TB] directed vectors, BPC=1");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, dirVecs[i].m, dirVecs[i].d, dirVecs[i].e,
                    dirVecs[i].ovf, dirVecs[i].zero, 12);
    end

    $display("[TB] hold and back-to-back");
    driveIn(1'b0, 1'b1, TC_NEG, 12'h007);
    tick();
    driveIn(1'b0, 1'b0, TC_NEG, 12'h007);
    waitResult(1'b0, edges);
    checkOutput("holdFirstLatency", edges, 12);
    driveIn(1'b0, 1'b1, TC_NEG, 12'h003);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("holdValid",   {31'd0, outValid(1'b0)}, 32'd1);
      checkOutput("holdData",    {20'd0, outData(1'b0)},  32'h0000_0FF9);
      checkOutput("holdInReady", {31'd0, inReady(1'b0)},  32'd0);
    end
    setOutReady(1'b0, 1'b1);
    tick();
    setOutReady(1'b0, 1'b0);
    driveIn(1'b0, 1'b0, TC_NEG, 12'h003);
    checkOutput("b2bValidDrop", {31'd0, outValid(1'b0)}, 32'd0);
    checkOutput("b2bBusy",      {31'd0, busyOf(1'b0)},   32'd1);
    waitResult(1'b0, edges);
    checkOutput("b2bLatency", edges, 12);
    checkOutput("b2bData", {20'd0, outData(1'b0)}, 32'h0000_0FFD);
    setOutReady(1'b0, 1'b1);
    tick();
    setOutReady(1'b0, 1'b0);

    $display("[TB] abort by reset mid-run");
    driveIn(1'b0, 1'b1, TC_PASS, 12'hABC);
    tick();
    driveIn(1'b0, 1'b0, TC_PASS, 12'hABC);
    repeat (5) tick();
    t_rst = 1'b1;
    tick();
    t_rst = 1'b0;
    checkOutput("abortOutValid", {31'd0, outValid(1'b0)}, 32'd0);
    checkOutput("abortBusy",     {31'd0, busyOf(1'b0)},   32'd0);
    checkOutput("abortInReady",  {31'd0, inReady(1'b0)},  32'd1);
    checkOutput("abortOutData",  {20'd0, outData(1'b0)},  32'd0);
    sawValid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      sawValid = sawValid | outValid(1'b0);
    end
    checkOutput("abortNoEmit", {31'd0, sawValid}, 32'd0);

    $display("[TB] BPC=4 latency");
    applyStimulus(1'b1, TC_NEG, 12'h005, 12'hFFB, 1'b0, 1'b0, 3);

    $display("[TB] random sweep, BPC=1");
    for (int i = 0; i < 200; i++) begin
      rm   = 2'($urandom_range(0, 3));
      rd   = 12'($urandom);
      expv = refModel(rm, rd);
      applyStimulus(1'b0, rm, rd, expv[11:0], expv[12], expv[13], 12);
    end

    $display("[TB] random sweep, BPC=4");
    for (int i = 0; i < 1000; i++) begin
      rm   = 2'($urandom_range(0, 3));
      rd   = 12'($urandom);
      if ((i % 50) == 0) rd = 12'h800;
      expv = refModel(rm, rd);
      applyStimulus(1'b1, rm, rd, expv[11:0], expv[12], expv[13], 3);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
